// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for an in-order pipeline: scoreboard of in-flight writers, forwarding select,
// load-use stall and branch/jump flush. HAZARD_PERF_CNT_EN adds saturating stall/flush counters.

module phc_entry_match #(
  parameter int RA_W = 5
) (
  input  logic            i_v,
  input  logic            i_wr,
  input  logic [RA_W-1:0] i_dst,
  input  logic [RA_W-1:0] i_rs,
  input  logic [RA_W-1:0] i_rt,
  input  logic            i_use_rs,
  input  logic            i_use_rt,
  output logic            o_hit_a,
  output logic            o_hit_b
);
  // A write to r0 is architecturally dead, so it never produces a hit.
  logic w_live;
  assign w_live  = i_v & i_wr & (i_dst != '0);
  assign o_hit_a = w_live & i_use_rs & (i_dst == i_rs);
  assign o_hit_b = w_live & i_use_rt & (i_dst == i_rt);
endmodule

module pipe_hazard_ctrl #(
  parameter int RA_W     = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int FW       = $clog2(DEPTH+1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic            id_wr_en,
  input  logic [RA_W-1:0] id_wr_dst,
  input  logic            id_is_load,
  input  logic            id_jump,
  input  logic            ex_branch_taken,
  output logic            pc_write,
  output logic            if_write,
  output logic            flush_if_id,
  output logic            bubble,
  output logic [1:0]      pc_sel,
  output logic [FW-1:0]   fwd_a_sel,
  output logic [FW-1:0]   fwd_b_sel,
  output logic [15:0]     stall_cnt,
  output logic [15:0]     flush_cnt
);

  // Entry 0 is the youngest in-flight instruction (EX), DEPTH-1 the oldest.
  logic [DEPTH-1:0]           r_v, r_wr, r_ld;
  logic [DEPTH-1:0][RA_W-1:0] r_dst;
  logic [DEPTH-1:0]           w_hit_a, w_hit_b;
  logic                       w_ld_hit, w_stall, w_issue;
  logic [FW-1:0]              w_fwd_a, w_fwd_b;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent
      phc_entry_match #(.RA_W(RA_W)) u_match (
        .i_v      (r_v[g]),
        .i_wr     (r_wr[g]),
        .i_dst    (r_dst[g]),
        .i_rs     (id_rs),
        .i_rt     (id_rt),
        .i_use_rs (id_use_rs),
        .i_use_rt (id_use_rt),
        .o_hit_a  (w_hit_a[g]),
        .o_hit_b  (w_hit_b[g])
      );
    end
  endgenerate

  always_comb begin
    w_ld_hit = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++)
      w_ld_hit = w_ld_hit | (r_ld[k] & (w_hit_a[k] | w_hit_b[k]));
  end

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    w_fwd_a = '0;
    w_fwd_b = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (w_hit_a[k]) w_fwd_a = FW'(k+1);
      if (w_hit_b[k]) w_fwd_b = FW'(k+1);
    end
  end

  assign w_stall   = id_valid & w_ld_hit;
  // A jump still issues; only a taken branch or a stall keeps decode out of the scoreboard.
  assign w_issue   = id_valid & ~w_stall & ~ex_branch_taken;
  assign fwd_a_sel = w_fwd_a;
  assign fwd_b_sel = w_fwd_b;

  always_comb begin
    pc_write    = 1'b1;
    if_write    = 1'b1;
    flush_if_id = 1'b0;
    bubble      = 1'b0;
    pc_sel      = 2'b00;
    if (ex_branch_taken) begin
      pc_sel      = 2'b10;
      flush_if_id = 1'b1;
      bubble      = 1'b1;
    end else if (w_stall) begin
      pc_write = 1'b0;
      if_write = 1'b0;
      bubble   = 1'b1;
    end else if (id_valid && id_jump) begin
      pc_sel      = 2'b01;
      flush_if_id = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v   <= '0;
      r_wr  <= '0;
      r_ld  <= '0;
      r_dst <= '0;
    end else begin
      r_v   <= {r_v[DEPTH-2:0],   w_issue};
      r_wr  <= {r_wr[DEPTH-2:0],  w_issue & id_wr_en};
      r_ld  <= {r_ld[DEPTH-2:0],  w_issue & id_is_load};
      r_dst <= {r_dst[DEPTH-2:0], (w_issue ? id_wr_dst : {RA_W{1'b0}})};
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] r_stall_cnt, r_flush_cnt;

  // A stall overridden by a taken branch is not a stall cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && !ex_branch_taken && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (flush_if_id && r_flush_cnt != 16'hFFFF)
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: main instance DEPTH=3/LOAD_LAT=1, second instance
// DEPTH=8/LOAD_LAT=7 used for stall-length and counter saturation.

module tb_pipe_hazard_ctrl;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       v, urs, urt, wr, ld, jmp, br;
  logic [4:0] rs, rt, dst;
  logic       pcw, ifw, fl, bub;
  logic [1:0] pcs, fa, fb;
  logic [15:0] scnt, fcnt;

  logic       b_v, b_urs, b_wr, b_ld;
  logic [4:0] b_rs, b_dst;
  logic       b_pcw, b_ifw, b_fl, b_bub;
  logic [1:0] b_pcs;
  logic [3:0] b_fa, b_fb;
  logic [15:0] b_scnt, b_fcnt;

  int n_cmp = 0;
  int n_err = 0;
  int n_st;

  pipe_hazard_ctrl #(.RA_W(5), .DEPTH(3), .LOAD_LAT(1)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(v), .id_rs(rs), .id_rt(rt),
    .id_use_rs(urs), .id_use_rt(urt), .id_wr_en(wr), .id_wr_dst(dst),
    .id_is_load(ld), .id_jump(jmp), .ex_branch_taken(br),
    .pc_write(pcw), .if_write(ifw), .flush_if_id(fl), .bubble(bub), .pc_sel(pcs),
    .fwd_a_sel(fa), .fwd_b_sel(fb), .stall_cnt(scnt), .flush_cnt(fcnt)
  );

  pipe_hazard_ctrl #(.RA_W(5), .DEPTH(8), .LOAD_LAT(7)) dut_sat (
    .clk(clk), .reset_n(reset_n), .id_valid(b_v), .id_rs(b_rs), .id_rt(5'd0),
    .id_use_rs(b_urs), .id_use_rt(1'b0), .id_wr_en(b_wr), .id_wr_dst(b_dst),
    .id_is_load(b_ld), .id_jump(1'b0), .ex_branch_taken(1'b0),
    .pc_write(b_pcw), .if_write(b_ifw), .flush_if_id(b_fl), .bubble(b_bub), .pc_sel(b_pcs),
    .fwd_a_sel(b_fa), .fwd_b_sel(b_fb), .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic iv, input logic [4:0] irs, input logic [4:0] irt,
                     input logic iurs, input logic iurt, input logic iwr,
                     input logic [4:0] idst, input logic ild, input logic ijmp, input logic ibr);
    v = iv; rs = irs; rt = irt; urs = iurs; urt = iurt;
    wr = iwr; dst = idst; ld = ild; jmp = ijmp; br = ibr;
    #1;
  endtask

  initial begin
    v = 0; rs = 0; rt = 0; urs = 0; urt = 0; wr = 0; dst = 0; ld = 0; jmp = 0; br = 0;
    b_v = 0; b_rs = 0; b_urs = 0; b_wr = 0; b_dst = 0; b_ld = 0;
    #3;
    chk("rst_pc_write", pcw, 1);
    chk("rst_if_write", ifw, 1);
    chk("rst_flush", fl, 0);
    chk("rst_bubble", bub, 0);
    chk("rst_pc_sel", pcs, 0);
    chk("rst_fwd_a", fa, 0);
    chk("rst_fwd_b", fb, 0);
    chk("rst_stall_cnt", scnt, 0);
    chk("rst_flush_cnt", fcnt, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // lw r5 ; add r6,r5,r7
    drv(1, 1, 0, 1, 0, 1, 5, 1, 0, 0);
    chk("lw_issue_pc_write", pcw, 1);
    cyc();
    drv(1, 5, 7, 1, 1, 1, 6, 0, 0, 0);
    chk("lu_bubble", bub, 1);
    chk("lu_pc_write", pcw, 0);
    chk("lu_if_write", ifw, 0);
    chk("lu_pc_sel", pcs, 0);
    chk("lu_fwd_a_e0", fa, 1);
    cyc(); #1;
    chk("lu_rel_bubble", bub, 0);
    chk("lu_rel_pc_write", pcw, 1);
    chk("lu_rel_fwd_a", fa, 2);
    chk("lu_rel_fwd_b", fb, 0);
    chk("lu_rel_stall_cnt", scnt, PERF ? 1 : 0);
    cyc();

    // add r3,r1,r2 ; sub r4,r3,r3 ; reader with use_rs off
    drv(1, 1, 2, 1, 1, 1, 3, 0, 0, 0);
    chk("alu_fwd_a_none", fa, 0);
    cyc();
    drv(1, 3, 3, 1, 1, 1, 4, 0, 0, 0);
    chk("alu_bubble", bub, 0);
    chk("alu_fwd_a", fa, 1);
    chk("alu_fwd_b", fb, 1);
    cyc();
    drv(1, 3, 3, 0, 1, 0, 0, 0, 0, 0);
    chk("nouse_fwd_a", fa, 0);
    chk("nouse_fwd_b", fb, 2);
    cyc();

    // Writers to r8 at entries 0 and 2; then same with r0 loads
    drv(1, 0, 0, 0, 0, 1, 8, 0, 0, 0); cyc();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
    drv(1, 0, 8, 0, 1, 1, 8, 0, 0, 0);
    chk("r8_fwd_b_e1", fb, 2);
    cyc();
    drv(1, 8, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("r8_youngest", fa, 1);
    cyc();
    drv(1, 0, 0, 0, 0, 1, 0, 1, 0, 0); cyc();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
    drv(1, 0, 0, 0, 0, 1, 0, 1, 0, 0); cyc();
    drv(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    chk("r0_fwd_a", fa, 0);
    chk("r0_fwd_b", fb, 0);
    chk("r0_no_stall_bubble", bub, 0);
    chk("r0_no_stall_pcw", pcw, 1);
    cyc();

    // Load-use stall with a taken branch in the same cycle
    drv(1, 0, 0, 0, 0, 1, 9, 1, 0, 0); cyc();
    drv(1, 9, 0, 1, 0, 1, 1, 0, 0, 1);
    chk("brst_pc_sel", pcs, 2);
    chk("brst_flush", fl, 1);
    chk("brst_bubble", bub, 1);
    chk("brst_pc_write", pcw, 1);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("brst_stall_cnt", scnt, PERF ? 1 : 0);
    chk("brst_flush_cnt", fcnt, PERF ? 1 : 0);
    cyc();

    // Jump issues into the scoreboard; a stalled jump waits
    drv(1, 0, 0, 0, 0, 1, 10, 0, 1, 0);
    chk("jmp_pc_sel", pcs, 1);
    chk("jmp_flush", fl, 1);
    chk("jmp_pc_write", pcw, 1);
    chk("jmp_bubble", bub, 0);
    cyc();
    drv(1, 10, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("jmp_issued_fwd", fa, 1);
    chk("jmp_flush_cnt", fcnt, PERF ? 2 : 0);
    cyc();
    drv(1, 0, 0, 0, 0, 1, 11, 1, 0, 0); cyc();
    drv(1, 11, 0, 1, 0, 0, 0, 0, 1, 0);
    chk("jst_pc_sel", pcs, 0);
    chk("jst_flush", fl, 0);
    chk("jst_pc_write", pcw, 0);
    chk("jst_bubble", bub, 1);
    cyc(); #1;
    chk("jst_rel_pc_sel", pcs, 1);
    chk("jst_rel_flush", fl, 1);
    chk("jst_rel_stall_cnt", scnt, PERF ? 2 : 0);
    cyc();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("brjmp_pc_sel", pcs, 2);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("brjmp_flush_cnt", fcnt, PERF ? 4 : 0);
    cyc();

    // Reset dropped in the middle of a stall
    drv(1, 0, 0, 0, 0, 1, 5, 1, 0, 0); cyc();
    drv(1, 5, 0, 1, 0, 1, 6, 0, 0, 0);
    chk("mrst_pre_bubble", bub, 1);
    reset_n = 1'b0;
    #1;
    chk("mrst_pc_write", pcw, 1);
    chk("mrst_if_write", ifw, 1);
    chk("mrst_bubble", bub, 0);
    chk("mrst_fwd_a", fa, 0);
    chk("mrst_stall_cnt", scnt, 0);
    chk("mrst_flush_cnt", fcnt, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    #1;
    chk("post_rst_fwd_a", fa, 0);
    chk("post_rst_pc_write", pcw, 1);
    chk("post_rst_bubble", bub, 0);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Self-dependent load on the deep instance: 7 stall cycles per issue
    b_v = 1; b_rs = 5; b_urs = 1; b_wr = 1; b_dst = 5; b_ld = 1;
    n_st = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (!b_pcw) n_st++;
      @(posedge clk); #1;
    end
    chk("deep_stall_cycles", n_st, 14);
    chk("deep_stall_cnt", b_scnt, PERF ? 14 : 0);
    if (PERF) repeat (75000) @(posedge clk);
    else repeat (200) @(posedge clk);
    #2;
    chk("sat_stall_cnt", b_scnt, PERF ? 32'hFFFF : 0);
    chk("sat_flush_cnt", b_fcnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
